fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RV32I core. It replaces the clock-gated PC register, PC+4 adder and PC mux with a clock-enabled fetch engine. The engine issues requests to a latency-tolerant instruction memory, buffers returned instructions with their PCs in a prefetch FIFO, and hands them to decode over a valid/ready interface. Redirects from branch, JAL and JALR resolution flush the buffer and discard in-flight responses.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, prefetch entries; power of 2, >= 2; also the cap on outstanding requests
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- run_i  input  1  start request; sticky once sampled high
- redirect_i  input  1  redirect fetch stream (branch/jump taken)
- redirect_pc_i  input  XLEN  redirect target; bits [1:0] forced to 0
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  XLEN  fetch address (word aligned)
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  in-order response valid
- imem_rdata_i  input  XLEN  response instruction
- instr_valid_o  output  1  FIFO head valid
- instr_ready_i  input  1  decode accepts head
- instr_o  output  XLEN  head instruction
- pc_o  output  XLEN  head PC
- pc_plus4_o  output  XLEN  pc_o + 4, modulo 2^XLEN
- running_o  output  1  run latch state

## Operation
- Run latch: running_o sets on any clk edge with run_i=1 and clears only on rst. No requests are issued while running_o=0.
- Credits: inflight counts granted requests whose responses are not yet returned. count is the number of FIFO entries. drop is the number of stale responses still to discard. All counters are $clog2(FIFO_DEPTH)+1 bits.
- imem_req_o = running_o & !redirect_i & (inflight + count < FIFO_DEPTH).
- imem_addr_o = fetch_pc.
- On req & gnt: fetch_pc += 4 (wraps at 2^XLEN) and inflight++.
- On imem_rvalid_i: inflight--. If drop>0, the data is discarded and drop decrements. Otherwise {resp_pc, imem_rdata_i} is pushed and resp_pc += 4. An rvalid with inflight=0 is a protocol error; an assertion fires.
- Pop on instr_valid_o & instr_ready_i.
- Redirect (priority over every other event in the same cycle):
  - FIFO is flushed and any same-cycle push or pop is ignored.
  - fetch_pc and resp_pc are set to {redirect_pc_i[XLEN-1:2],2'b00}.
  - drop is set to inflight minus (1 if rvalid this cycle). Gnt is impossible during the redirect cycle because the request is masked.
- A redirect while running_o=0 updates the PCs only.
- Back-pressure: a full FIFO holding ready low stalls requests through the credit rule. No response is ever lost.

## Timing
- Reset values:
  - imem_req_o=0, instr_valid_o=0, running_o=0
  - instr_o=0, pc_o=0, pc_plus4_o=4 (FIFO storage reset to 0)
  - imem_addr_o=RESET_PC
  - inflight, count, drop all 0
- Start: with run_i high at edge N, imem_req_o can assert in cycle N+1.
- FIFO is registered and has no bypass. An rvalid in cycle C gives instr_valid_o in cycle C+1.
- Redirect at edge E:
  - request for the target in cycle E+1
  - with gnt in E+1 and rvalid in E+2, instr_valid_o with pc_o=target in E+3
- Steady-state throughput is 1 instr/cycle when gnt=1, memory latency is 1 and ready=1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Simultaneous push and pop on an empty FIFO cannot occur; pop requires valid.
- rst mid-operation clears all state immediately. In-flight responses arriving after rst deasserts are a bench/memory error; memory is reset together with the core.

## Structure
- fetch_pkg:
  - fetch_entry_t packed struct {pc, instr}
  - NOP_INSTR = 32'h0000_0013
  - XLEN default constant
- Sub-module sync_fifo: parameters WIDTH and DEPTH; synchronous flush; push, pop, full, empty and count; async reset clears pointers and storage. It holds fetch_entry_t entries.
- fetch_unit contains the run latch, fetch_pc, resp_pc, the credit/drop counters and the pc_plus4 adder.

## Test plan
- Reset with run_i=0, then release -> imem_req_o=0 for 10 cycles; running_o=0; pc_plus4_o=4.
- run_i pulse, gnt=1, 1-cycle latency, ready=1, RESET_PC=0 -> pc_o sequence 0,4,8,12 on consecutive cycles, each instr_o matching memory.
- ready=0 for 20 cycles, FIFO_DEPTH=4 -> exactly 4 grants, then imem_req_o=0. On ready=1, stream resumes at pc 0x10 with no gap or duplicate.
- Memory latency 3 with 2 requests in flight, redirect to 0x103 -> both stale responses dropped; the next pc_o is 0x100 and is followed by 0x104.
- Redirect in the same cycle as a pop and an rvalid -> FIFO empty next cycle; drop = inflight-1; no stale entry appears.
- fetch_pc at 0xFFFF_FFFC -> next imem_addr_o=0; pc_plus4_o for the head entry at 0xFFFF_FFFC is 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// A prefetch entry pairs an instruction with the PC it was fetched from.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO without bypass; head data is valid the cycle after a push.
// Flush has priority over push and pop; reset also clears the storage array.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Clock-enabled instruction fetch engine: credit-limited request issue, in-order
// response capture into a prefetch FIFO, and redirect with stale-response dropping.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            running_o
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int              EW         = $bits(fetch_entry_t);
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            r_running;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [XLEN-1:0] w_target;
    logic            w_req;
    logic            w_grant;
    logic            w_drop_resp;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_fifo_rdata;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_target    = redirect_pc_i & ALIGN_MASK;
    // Outstanding requests plus buffered entries never exceed the FIFO size,
    // so every response always has a slot waiting for it.
    assign w_req       = r_running && !redirect_i
                         && (({1'b0, r_inflight} + {1'b0, w_count}) < CREDIT_MAX);
    assign w_grant     = w_req && imem_gnt_i;
    assign w_drop_resp = imem_rvalid_i && (r_drop != '0);
    assign w_push      = imem_rvalid_i && !w_drop_resp && !redirect_i;
    assign w_pop       = !w_fifo_empty && instr_ready_i;

    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = imem_rdata_i;
    assign w_head             = fetch_entry_t'(w_fifo_rdata);

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;
    assign pc_plus4_o    = w_head.pc + PC_STEP;
    assign running_o     = r_running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running <= 1'b0;
        end else if (run_i) begin
            r_running <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_grant, imem_rvalid_i})
                2'b10:   r_inflight <= r_inflight + CNT_ONE;
                2'b01:   r_inflight <= r_inflight - CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A response arriving in the redirect cycle is already discarded, so it is
    // not counted among the stale responses still to come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else if (redirect_i) begin
            r_drop <= r_inflight - (imem_rvalid_i ? CNT_ONE : '0);
        end else if (w_drop_resp) begin
            r_drop <= r_drop - CNT_ONE;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    a_rvalid_has_credit: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid_i |-> (r_inflight != '0));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) (w_push && w_fifo_full) |-> w_pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed stimulus for fetch_unit against a queue-level model
// of the fetch stream (outstanding requests, prefetch buffer, expected PCs).
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        running_o;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .running_o     (running_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] pc; bit stale; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int rt; } mem_t;
    typedef struct { int cyc; logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } log_t;

    out_t m_out[$];
    ent_t m_fifo[$];
    mem_t mem_q[$];
    log_t pop_log[$];

    bit          m_running;
    logic [31:0] m_fetch_pc;
    logic        m_req;
    out_t        e_tmp;
    mem_t        mt_tmp;
    log_t        lg_tmp;
    int          n_gnt, last_rt, rt;
    int          lat_min = 1, lat_max = 1;
    int          n_cmp = 0, n_err = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req",     32'(imem_req_o),    32'd0);
            chk("rst_valid",   32'(instr_valid_o), 32'd0);
            chk("rst_running", 32'(running_o),     32'd0);
            chk("rst_instr",   instr_o,            32'd0);
            chk("rst_pc",      pc_o,               32'd0);
            chk("rst_pc4",     pc_plus4_o,         32'd4);
            chk("rst_addr",    imem_addr_o,        32'd0);
            m_running  = 1'b0;
            m_fetch_pc = 32'd0;
            m_out.delete();
            m_fifo.delete();
            mem_q.delete();
            n_gnt   = 0;
            last_rt = 0;
        end else begin
            m_req = m_running && !redirect_i && ((m_out.size() + m_fifo.size()) < DEPTH);
            chk("running", 32'(running_o),     32'(m_running));
            chk("req",     32'(imem_req_o),    32'(m_req));
            chk("addr",    imem_addr_o,        m_fetch_pc);
            chk("valid",   32'(instr_valid_o), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("pc",    pc_o,       m_fifo[0].pc);
                chk("instr", instr_o,    m_fifo[0].instr);
                chk("pc4",   pc_plus4_o, m_fifo[0].pc + 32'd4);
            end

            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                lg_tmp = '{cyc, pc_o, instr_o, pc_plus4_o};
                pop_log.push_back(lg_tmp);
            end
            // Memory: in-order responses, each at least its latency after grant.
            if (imem_req_o && imem_gnt_i) begin
                n_gnt++;
                rt = cyc + $urandom_range(lat_max, lat_min);
                if (rt <= last_rt) rt = last_rt + 1;
                last_rt = rt;
                mt_tmp = '{imem_addr_o, rt};
                mem_q.push_back(mt_tmp);
            end
            if (imem_rvalid_i && mem_q.size() != 0) mt_tmp = mem_q.pop_front();

            m_running = m_running | run_i;
            if (redirect_i) begin
                if (imem_rvalid_i && m_out.size() != 0) e_tmp = m_out.pop_front();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_fifo.delete();
                m_fetch_pc = redirect_pc_i & ~32'd3;
            end else begin
                if (m_fifo.size() != 0 && instr_ready_i) void'(m_fifo.pop_front());
                if (imem_rvalid_i && m_out.size() != 0) begin
                    e_tmp = m_out.pop_front();
                    if (!e_tmp.stale) m_fifo.push_back('{e_tmp.pc, memf(e_tmp.pc)});
                end
                if (m_req && imem_gnt_i) begin
                    m_out.push_back('{m_fetch_pc, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && mem_q.size() != 0 && mem_q[0].rt <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memf(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_rvalid_i = 1'b0;
        run_i = 1'b0;
        redirect_i = 1'b0;
        imem_gnt_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pop_log.delete();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("pops_seen", 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic start_run();
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        instr_ready_i = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: nothing is requested without run.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_req",     32'(imem_req_o), 32'd0);
            chk("idle_running", 32'(running_o),  32'd0);
            chk("idle_pc4",     pc_plus4_o,      32'd4);
        end

        // Back-to-back stream from RESET_PC.
        imem_gnt_i = 1'b1;
        lat_min = 1; lat_max = 1;
        pop_log.delete();
        start_run();
        wait_pops(4, 30);
        if (pop_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_pc",     pop_log[i].pc,    32'(i * 4));
                chk("t2_instr",  pop_log[i].instr, memf(32'(i * 4)));
                chk("t2_consec", 32'(pop_log[i].cyc), 32'(pop_log[0].cyc + i));
            end
        end

        // Back-pressure: credits stop at FIFO_DEPTH, then resume without gap.
        do_reset();
        instr_ready_i = 1'b0;
        imem_gnt_i = 1'b1;
        start_run();
        repeat (20) tick();
        chk("t3_grants", 32'(n_gnt),         32'd4);
        chk("t3_req",    32'(imem_req_o),    32'd0);
        chk("t3_valid",  32'(instr_valid_o), 32'd1);
        instr_ready_i = 1'b1;
        pop_log.delete();
        wait_pops(8, 40);
        if (pop_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t3_pc",     pop_log[i].pc,       32'(i * 4));
                chk("t3_consec", 32'(pop_log[i].cyc), 32'(pop_log[0].cyc + i));
            end
        end

        // Redirect with two responses still in flight at latency 3.
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_gnt_i = 1'b0;
        start_run();
        chk("t4_req", 32'(imem_req_o), 32'd1);
        imem_gnt_i = 1'b1;
        tick();
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        pop_log.delete();
        wait_pops(2, 40);
        if (pop_log.size() >= 2) begin
            chk("t4_pc0", pop_log[0].pc, 32'h100);
            chk("t4_pc1", pop_log[1].pc, 32'h104);
        end

        // Redirect coinciding with a pop and a returning response.
        do_reset();
        lat_min = 2; lat_max = 2;
        imem_gnt_i = 1'b1;
        start_run();
        wait_pops(3, 40);
        for (int k = 0; k < 20 && !(instr_valid_o && imem_rvalid_i); k++) tick();
        chk("t5_setup", 32'(instr_valid_o && imem_rvalid_i), 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        pop_log.delete();
        tick();
        redirect_i = 1'b0;
        chk("t5_flushed", 32'(instr_valid_o), 32'd0);
        wait_pops(2, 40);
        if (pop_log.size() >= 2) begin
            chk("t5_pc0", pop_log[0].pc, 32'h200);
            chk("t5_pc1", pop_log[1].pc, 32'h204);
        end

        // Address wrap at the top of the address space.
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_gnt_i = 1'b0;
        start_run();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        chk("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        pop_log.delete();
        tick();
        chk("t6_addr_wrap", imem_addr_o, 32'h0);
        wait_pops(2, 30);
        if (pop_log.size() >= 2) begin
            chk("t6_pc0",  pop_log[0].pc,  32'hFFFF_FFFC);
            chk("t6_pc40", pop_log[0].pc4, 32'h0);
            chk("t6_pc1",  pop_log[1].pc,  32'h0);
        end

        // Random traffic with variable latency, redirects and a mid-run reset.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            tick();
            imem_gnt_i    = ($urandom_range(3, 0) != 0);
            instr_ready_i = ($urandom_range(3, 0) != 0);
            run_i         = (i % 1500 > 20) && ($urandom_range(7, 0) == 0);
            redirect_i    = ($urandom_range(19, 0) == 0);
            redirect_pc_i = $urandom;
        end
        redirect_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
